// File: rtl/ant_pair_write_sched.sv
// Write-side scheduler for the dual-bank antenna buffer: grants one requester per even/odd symbol pair.
// Optional ANT_PAIR_SCHED_ERR_CNT_EN adds o_err_cnt, a saturating count of length errors.
module ant_pair_write_sched #(
  parameter int ANT         = 4,
  parameter int NREQ        = 2,
  parameter int WADDR_WIDTH = 11,
  parameter int RE_NUM      = 1584,
  parameter int CREDITS     = 2
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [NREQ-1:0]                   i_s_valid,
  input  logic [NREQ-1:0][ANT*32-1:0]       i_s_data,
  input  logic [NREQ-1:0]                   i_s_last,
  output logic [NREQ-1:0]                   o_s_ready,
  output logic [WADDR_WIDTH-1:0]            o_iq_addr,
  output logic [ANT*32-1:0]                 o_iq_data,
  output logic                              o_iq_vld,
  output logic                              o_iq_last,
  input  logic                              i_rd_eop,
  output logic [NREQ-1:0]                   o_grant,
  output logic [2:0]                        o_credit,
  output logic                              o_len_err
`ifdef ANT_PAIR_SCHED_ERR_CNT_EN
  ,
  output logic [15:0]                       o_err_cnt
`endif
);

  localparam int                     OW        = $clog2(NREQ);
  localparam logic [WADDR_WIDTH-1:0] LAST_ADDR = WADDR_WIDTH'(RE_NUM - 1);
  localparam logic [2:0]             CRED_MAX  = 3'(CREDITS);

  typedef enum logic [1:0] {IDLE, EVEN, ODD, DRAIN} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_drain_odd, w_drain_odd_nxt;
  logic [OW-1:0]          r_owner, w_owner_nxt;
  logic [WADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]             r_credit, w_credit_nxt;
  logic [3:0]             w_credit_sum;
  logic [OW-1:0]          w_idx, w_pick;
  logic                   w_found, w_grant_fire;
  logic                   w_beat, w_sel_last, w_at_end;
  logic                   w_write, w_wr_last, w_wr_err;

  logic                   r_iq_vld, r_iq_last, r_len_err;
  logic [WADDR_WIDTH-1:0] r_iq_addr;
  logic [ANT*32-1:0]      r_iq_data;

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_odd_nxt = r_drain_odd;
    w_owner_nxt     = r_owner;
    w_cnt_nxt       = r_cnt;
    w_grant_fire    = 1'b0;
    w_write         = 1'b0;
    w_wr_last       = 1'b0;
    w_wr_err        = 1'b0;
    w_found         = 1'b0;
    w_pick          = r_owner;
    w_idx           = r_owner;
    w_beat          = (r_state != IDLE) && i_s_valid[r_owner];
    w_sel_last      = i_s_last[r_owner];
    w_at_end        = (r_cnt == LAST_ADDR);

    // Round-robin search starting one past the last owner.
    for (int i = 0; i < NREQ; i++) begin
      w_idx = (w_idx == OW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      if (!w_found && i_s_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end

    case (r_state)
      IDLE: begin
        w_grant_fire = w_found && ((r_credit != 3'd0) || i_rd_eop);
        if (w_grant_fire) begin
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = EVEN;
        end
      end
      EVEN, ODD: begin
        if (w_beat) begin
          w_write   = 1'b1;
          w_wr_last = w_at_end | w_sel_last;
          w_wr_err  = w_at_end ^ w_sel_last;
          w_cnt_nxt = w_wr_last ? '0 : r_cnt + 1'b1;
          if (w_sel_last) begin
            w_state_nxt = (r_state == EVEN) ? ODD : IDLE;
          end else if (w_at_end) begin
            w_state_nxt     = DRAIN;
            w_drain_odd_nxt = (r_state == ODD);
          end
        end
      end
      DRAIN: begin
        if (w_beat && w_sel_last) w_state_nxt = r_drain_odd ? IDLE : ODD;
      end
      default: w_state_nxt = IDLE;
    endcase

    // A credit returned in the same cycle as a grant is usable by that grant.
    w_credit_sum = {1'b0, r_credit} + {3'b000, i_rd_eop} - {3'b000, w_grant_fire};
    w_credit_nxt = (w_credit_sum > {1'b0, CRED_MAX}) ? CRED_MAX : w_credit_sum[2:0];
  end

  // Owner resets to the last index so the first search after reset starts at requester 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_drain_odd <= 1'b0;
      r_owner     <= OW'(NREQ - 1);
      r_cnt       <= '0;
      r_credit    <= CRED_MAX;
      r_iq_vld    <= 1'b0;
      r_iq_last   <= 1'b0;
      r_len_err   <= 1'b0;
      r_iq_addr   <= '0;
      r_iq_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_odd <= w_drain_odd_nxt;
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_credit    <= w_credit_nxt;
      r_iq_vld    <= w_write;
      r_iq_last   <= w_wr_last;
      r_len_err   <= w_wr_err;
      if (w_write) begin
        r_iq_addr <= r_cnt;
        r_iq_data <= i_s_data[r_owner];
      end
    end
  end

  assign o_grant   = (r_state != IDLE) ? (NREQ'(1) << r_owner) : '0;
  assign o_s_ready = o_grant;
  assign o_credit  = r_credit;
  assign o_iq_vld  = r_iq_vld;
  assign o_iq_last = r_iq_last;
  assign o_iq_addr = r_iq_addr;
  assign o_iq_data = r_iq_data;
  assign o_len_err = r_len_err;

`ifdef ANT_PAIR_SCHED_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_cnt <= '0;
    end else if (r_len_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_ant_pair_write_sched.sv
// Scoreboard bench for ant_pair_write_sched: a pair-level model predicts grant order and every buffer write.
// Honours ANT_PAIR_SCHED_ERR_CNT_EN when the design is built with it.
module tb_ant_pair_write_sched;

  localparam int ANT         = 4;
  localparam int NREQ        = 2;
  localparam int WADDR_WIDTH = 11;
  localparam int RE_NUM      = 1584;
  localparam int CREDITS     = 2;
  localparam int DW          = ANT * 32;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    bit            first;
  } beat_t;

  typedef struct {
    logic [WADDR_WIDTH-1:0] addr;
    logic [DW-1:0]          data;
    bit                     last;
    bit                     err;
    logic [NREQ-1:0]        grant;
    bit                     first;
  } exp_t;

  typedef struct {
    int len0;
    int len1;
    bit trunc;
  } pair_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        sValid;
  logic [NREQ-1:0][DW-1:0] sData;
  logic [NREQ-1:0]        sLast;
  logic [NREQ-1:0]        oSReady;
  logic [WADDR_WIDTH-1:0] oIqAddr;
  logic [DW-1:0]          oIqData;
  logic                   oIqVld;
  logic                   oIqLast;
  logic                   rdEop;
  logic [NREQ-1:0]        oGrant;
  logic [2:0]             oCredit;
  logic                   oLenErr;
`ifdef ANT_PAIR_SCHED_ERR_CNT_EN
  logic [15:0]            errCnt;
`endif

  beat_t drvQ[NREQ][$];
  pair_t pendQ[NREQ][$];
  exp_t  expQ[$];

  int  nChecks = 0;
  int  nFail   = 0;
  int  cyc     = 0;
  int  rrLast, expCredit, pairId, expErr, firstWrCyc, lastWrCyc, wrCount;
  bit  gapsEn, eopAuto, monEn;

  ant_pair_write_sched #(
    .ANT(ANT), .NREQ(NREQ), .WADDR_WIDTH(WADDR_WIDTH), .RE_NUM(RE_NUM), .CREDITS(CREDITS)
  ) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_s_valid(sValid),
    .i_s_data (sData),
    .i_s_last (sLast),
    .o_s_ready(oSReady),
    .o_iq_addr(oIqAddr),
    .o_iq_data(oIqData),
    .o_iq_vld (oIqVld),
    .o_iq_last(oIqLast),
    .i_rd_eop (rdEop),
    .o_grant  (oGrant),
    .o_credit (oCredit),
    .o_len_err(oLenErr)
`ifdef ANT_PAIR_SCHED_ERR_CNT_EN
    ,
    .o_err_cnt(errCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " s_ready"}, 32'(oSReady), 0);
    checkOutput({tag, " grant"}, 32'(oGrant), 0);
    checkOutput({tag, " iq_vld"}, 32'(oIqVld), 0);
    checkOutput({tag, " iq_last"}, 32'(oIqLast), 0);
    checkOutput({tag, " iq_addr"}, 32'(oIqAddr), 0);
    checkOutput({tag, " iq_data nonzero"}, 32'(oIqData != '0), 0);
    checkOutput({tag, " len_err"}, 32'(oLenErr), 0);
    checkOutput({tag, " credit"}, 32'(oCredit), CREDITS);
  endtask

  // Expand one granted pair into the requester's beat stream and the expected buffer writes.
  task automatic buildPair(input int r, input pair_t p);
    int lens[2];
    lens[0] = p.len0;
    lens[1] = p.len1;
    pairId++;
    for (int s = 0; s < 2; s++) begin
      int nw;
      bit open;
      nw   = (lens[s] < RE_NUM) ? lens[s] : RE_NUM;
      open = p.trunc && (s == 1);
      for (int b = 0; b < lens[s]; b++) begin
        beat_t bt;
        exp_t  e;
        bt.data  = {$urandom(), $urandom(), $urandom(), 8'(r), 8'(pairId), 1'(s), 15'(b)};
        bt.last  = !open && (b == lens[s] - 1);
        bt.first = (s == 0) && (b == 0);
        drvQ[r].push_back(bt);
        if (b < nw) begin
          e.addr  = WADDR_WIDTH'(b);
          e.data  = bt.data;
          e.last  = !open && (b == nw - 1);
          e.err   = e.last && (lens[s] != RE_NUM);
          e.grant = (s == 1 && !open && b == lens[s] - 1) ? '0 : NREQ'(1 << r);
          e.first = bt.first;
          expQ.push_back(e);
          if (e.err) expErr++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input int r, input int len0, input int len1, input bit trunc);
    pair_t p;
    p.len0  = len0;
    p.len1  = len1;
    p.trunc = trunc;
    pendQ[r].push_back(p);
  endtask

  // Pending pairs are served round-robin, one whole pair per grant.
  task automatic planBatch();
    int pick;
    bit any;
    while (1) begin
      any  = 0;
      pick = 0;
      for (int k = 1; k <= NREQ && !any; k++) begin
        pick = (rrLast + k) % NREQ;
        if (pendQ[pick].size() > 0) any = 1;
      end
      if (!any) break;
      buildPair(pick, pendQ[pick].pop_front());
      rrLast = pick;
    end
  endtask

  function automatic bit anyDrv();
    bit a = 0;
    for (int r = 0; r < NREQ; r++) if (drvQ[r].size() > 0) a = 1;
    return a;
  endfunction

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((expQ.size() != 0 || anyDrv()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    nChecks++;
    if (n >= budget) begin
      nFail++;
      $display("[TB] FAIL drain timeout: %0d writes still expected after %0d cycles, required 0", expQ.size(), budget);
      expQ.delete();
      for (int r = 0; r < NREQ; r++) drvQ[r].delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic runBatch(input int budget);
    planBatch();
    waitDrain(budget);
  endtask

  task automatic pulseEop(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) rdEop = 1'b1;
      @(negedge clk) rdEop = 1'b0;
    end
  endtask

  function automatic int randLen();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(RE_NUM - 40, RE_NUM + 20));
    return RE_NUM;
  endfunction

  // Requester drivers: hold a pair's first beat steady, optionally gap later beats.
  initial begin
    bit acc[NREQ];
    forever begin
      @(negedge clk);
      for (int r = 0; r < NREQ; r++) acc[r] = sValid[r] && oSReady[r];
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r] && drvQ[r].size() > 0) void'(drvQ[r].pop_front());
        if (drvQ[r].size() > 0) begin
          sValid[r] = drvQ[r][0].first || !gapsEn || ($urandom_range(0, 3) != 0);
          sData[r]  = drvQ[r][0].data;
          sLast[r]  = drvQ[r][0].last;
        end else begin
          sValid[r] = 1'b0;
          sLast[r]  = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (eopAuto) rdEop = ($urandom_range(0, 599) == 0);
    end
  end

  // Monitor: every buffer write must match the head of the expected queue.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      cyc++;
      if (monEn && oIqVld) begin
        nChecks++;
        wrCount++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("[TB] FAIL unexpected write: got addr=%0d data=%h, required no write", oIqAddr, oIqData);
        end else begin
          e = expQ.pop_front();
          if (e.first) firstWrCyc = cyc;
          lastWrCyc = cyc;
          if (oIqAddr !== e.addr || oIqData !== e.data || oIqLast !== e.last ||
              oLenErr !== e.err || oGrant !== e.grant) begin
            nFail++;
            $display("[TB] FAIL write %0d: got addr=%0d last=%0b err=%0b grant=%b data=%h, expected addr=%0d last=%0b err=%0b grant=%b data=%h",
                     wrCount, oIqAddr, oIqLast, oLenErr, oGrant, oIqData,
                     e.addr, e.last, e.err, e.grant, e.data);
          end
        end
      end
      if (monEn && oLenErr && !oIqVld) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL len_err without write: got len_err=1 vld=0, required vld=1");
      end
    end
  end

  initial begin
    beat_t extra;
    reset = 1'b1; rdEop = 1'b0; sValid = '0; sData = '0; sLast = '0;
    gapsEn = 0; eopAuto = 0; monEn = 0;
    rrLast = NREQ - 1; expCredit = CREDITS; pairId = 0; expErr = 0;
    firstWrCyc = 0; lastWrCyc = 0; wrCount = 0;
    repeat (3) @(negedge clk);
    checkReset("power-on");
    reset = 1'b0;
    monEn = 1;

    $display("[TB] single requester, two correct pairs");
    applyStimulus(0, RE_NUM, RE_NUM, 0);
    runBatch(8000);
    checkOutput("pair write span", 32'(lastWrCyc - firstWrCyc), 2 * RE_NUM - 1);
    expCredit--;
    checkOutput("credit after pair 1", 32'(oCredit), expCredit);
    applyStimulus(0, RE_NUM, RE_NUM, 0);
    runBatch(8000);
    expCredit--;
    checkOutput("credit after pair 2", 32'(oCredit), expCredit);

    $display("[TB] out of credit, then one returned");
    applyStimulus(1, RE_NUM, RE_NUM, 0);
    planBatch();
    repeat (40) @(negedge clk);
    checkOutput("ready held off", 32'(oSReady), 0);
    checkOutput("grant held off", 32'(oGrant), 0);
    checkOutput("no writes without credit", expQ.size(), 2 * RE_NUM);
    pulseEop(1);
    waitDrain(8000);
    checkOutput("credit after eop+grant", 32'(oCredit), 0);
    pulseEop(3);
    expCredit = CREDITS;
    checkOutput("credit saturates", 32'(oCredit), expCredit);

    $display("[TB] symbol length errors");
    applyStimulus(0, 1000, RE_NUM, 0);
    runBatch(8000);
    applyStimulus(1, 1600, RE_NUM, 0);
    runBatch(8000);
`ifdef ANT_PAIR_SCHED_ERR_CNT_EN
    checkOutput("err count", 32'(errCnt), expErr);
`endif
    pulseEop(2);
    applyStimulus(0, RE_NUM, RE_NUM + 6, 0);
    applyStimulus(1, RE_NUM, 7, 0);
    eopAuto = 1;
    runBatch(12000);
    eopAuto = 0;
    @(negedge clk) rdEop = 1'b0;
`ifdef ANT_PAIR_SCHED_ERR_CNT_EN
    checkOutput("err count", 32'(errCnt), expErr);
`endif

    $display("[TB] two requesters competing");
    eopAuto = 1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, RE_NUM, RE_NUM, 0);
      applyStimulus(1, RE_NUM, RE_NUM, 0);
    end
    runBatch(20000);

    $display("[TB] randomized pairs with gaps");
    gapsEn = 1;
    for (int i = 0; i < 4; i++) applyStimulus(int'($urandom_range(0, NREQ - 1)), randLen(), randLen(), 0);
    runBatch(30000);
    gapsEn = 0;
    eopAuto = 0;
    @(negedge clk) rdEop = 1'b0;
    pulseEop(CREDITS);
    expCredit = CREDITS;
    checkOutput("credit restored", 32'(oCredit), expCredit);
`ifdef ANT_PAIR_SCHED_ERR_CNT_EN
    checkOutput("err count", 32'(errCnt), expErr);
`endif

    $display("[TB] reset in the middle of the odd symbol");
    applyStimulus(1, RE_NUM, 500, 1);
    runBatch(8000);
    extra.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    extra.last  = 0;
    extra.first = 0;
    @(negedge clk);
    drvQ[1].push_back(extra);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkReset("mid-pair reset");
    rrLast = NREQ - 1;
    expCredit = CREDITS;
    expErr = 0;
    for (int r = 0; r < NREQ; r++) drvQ[r].delete();
    repeat (4) @(negedge clk);
    applyStimulus(1, RE_NUM, RE_NUM, 0);
    applyStimulus(0, RE_NUM, RE_NUM, 0);
    runBatch(12000);
    checkOutput("credit after two pairs", 32'(oCredit), expCredit - 2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
